led_probe_monitor: RTL
======================

Name: led_probe_monitor

Overview:
- Parametrised debug-display block for the experiment CPUs.
- Takes NCH probe words (register-file taps, ALU result, memory data, and so on) plus the PC.
- Selects one word with the switches and shows one LED-width byte lane of it on the LEDs.
- Lane selection is static, auto-scrolling, manual-step, or from a frozen snapshot.
- Sits between the CPU core and the board LEDs, replacing the fixed 2-bit-switch LED mux of earlier experiments.

Parameters:
- NCH, 4: number of probe channels (≥2).
- DW, 32: probe word width. Must be a multiple of LW.
- LW, 8: LED width.
- PCW, 6: displayed PC bits, pc_in[PCW+1:2].
- SCROLL_DIV, 50000000: clocks per lane advance in auto-scroll mode (≥1).
- Derived, not overridable:
  - SW_W = clog2(NCH).
  - NLANE = DW/LW.
  - LN_W = max(1, clog2(NLANE)).

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- sw, input, SW_W: probe channel select.
- mode, input, 2: 00 static, 01 auto-scroll, 10 snapshot, 11 manual-step.
- step, input, 1: level from a debounced button. The rising edge is used.
- probe, input, NCH*DW: flattened probes. Channel k occupies bits [k*DW +: DW].
- pc_in, input, 32: current CPU PC.
- led, output, LW: displayed byte lane.
- pc, output, PCW: displayed PC bits.
- lane, output, LN_W: current lane index.
- snap_valid, output, 1: snapshot held and on display.

Behaviour:
- Reset: when rst=1 at a clock edge, the following are all 0 after that edge:
  - led, pc, lane, snap_valid
  - prescaler
  - step_q
  - mode_q (previous mode)
  - snapshot registers
  - rst overrides every other input. Reset mid-scroll or mid-snapshot simply returns to these values.
- Registered outputs: all outputs are registered.
  - led and pc reflect inputs sampled at edge N, and are visible after edge N.
  - Latency is 1 clock.
- Step edge: step_q <= step every cycle. step_rise = step & ~step_q.
- Mode change: mode_chg = (mode != mode_q); mode_q <= mode every cycle. On mode_chg:
  - lane <= 0 and prescaler <= 0.
  - This has priority over a simultaneous step_rise or prescaler terminal count.
- Data source selection: src = probe channel sw (live), except in mode 10, where src = snapshot channel sw.
  - If sw ≥ NCH (non-power-of-2 NCH), led <= 0.
  - Otherwise led <= src[lane_next*LW +: LW], where lane_next is the lane value being written on the same edge, so a lane change and its data appear together.
- Mode 00, static: lane forced to 0. led shows lane 0 of the live selected probe. Prescaler held at 0.
- Mode 01, auto-scroll:
  - Prescaler counts 0..SCROLL_DIV-1.
  - At terminal count (SCROLL_DIV-1) it wraps to 0 and lane <= (lane==NLANE-1) ? 0 : lane+1.
  - step is ignored.
- Mode 11, manual-step: on step_rise, lane advances with the same wrap rule. Live data.
- Mode 10, snapshot:
  - On the entry cycle (mode_chg with mode==10), all NCH probes and pc_in are captured into the snapshot registers, and snap_valid <= 1.
  - While the mode is held, the snapshot is frozen regardless of probe/pc_in changes.
  - step_rise advances lane over the snapshot.
  - Leaving mode 10 clears snap_valid on that edge. Re-entering takes a fresh snapshot.
  - On the entry cycle, led shows lane 0 of the newly captured value. It does not show stale data.
- PC output:
  - pc <= pc_in[PCW+1:2] in modes 00/01/11.
  - pc <= snapshot_pc[PCW+1:2] in mode 10. The entry cycle uses the value being captured.
- Wrap: lane wraps NLANE-1 → 0 in both scroll and step. NLANE=1 keeps lane at 0 permanently.
- Channel switch: changing sw never resets lane or prescaler. Only the data source changes, on the next edge.

Test Plan:
Use NCH=4, DW=32, LW=8, PCW=6, SCROLL_DIV=4 for all scenarios.
1. Reset and static: rst=1 for 2 clocks, then 0.
   - During reset: led=0, pc=0, lane=0, snap_valid=0.
   - Then mode=00, sw=2, probe ch2=0xA1B2C3D4, pc_in=0x0000003C: one clock later led=0xD4, pc=0x0F, lane=0.
   - sw=3 with ch3=0x11223344 gives led=0x44.
2. Auto-scroll: mode=01, sw=0, ch0=0xDEADBEEF.
   - Lane advances every 4 clocks: led sequence 0xEF, 0xBE, 0xAD, 0xDE, 0xEF (wrap to lane 0).
   - rst asserted mid-sequence gives led=0, lane=0 on the next edge.
3. Manual step: mode=11, ch1=0x01020304, sw=1.
   - Three single-clock step pulses give led 0x03, 0x02, 0x01.
   - Holding step high for 5 clocks advances only once.
   - A step pulse on the same cycle as mode changing to 01 leaves lane=0.
4. Snapshot: ch0=0x12345678, pc_in=0x40, then mode=10.
   - Next clock: snap_valid=1, led=0x78, pc=0x10.
   - Change ch0 to 0xFFFFFFFF and pc_in to 0x80: led and pc unchanged.
   - Step pulse gives led=0x56.
   - mode=00 gives snap_valid=0, led=0xFF.
   - mode=10 again captures 0xFFFFFFFF.
5. Channel switch during scroll: mode=01 with lane=2, sw changed 0→1.
   - lane stays 2.
   - led shows ch1 bits [23:16] on the next edge.
   - Prescaler phase is undisturbed, so the next advance occurs on schedule.

Source files
------------

// File: rtl/led_probe_monitor.sv
// Debug display: picks one of NCH probe words (live or frozen snapshot) and shows
// one LED-wide byte lane of it; the lane is static, auto-scrolled or button-stepped.
module led_probe_monitor #(
    parameter int NCH        = 4,
    parameter int DW         = 32,
    parameter int LW         = 8,
    parameter int PCW        = 6,
    parameter int SCROLL_DIV = 50000000,
    localparam int SW_W      = $clog2(NCH),
    localparam int NLANE     = DW / LW,
    localparam int LN_W      = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw,
    input  logic [1:0]        mode,
    input  logic              step,
    input  logic [NCH*DW-1:0] probe,
    input  logic [31:0]       pc_in,
    output logic [LW-1:0]     led,
    output logic [PCW-1:0]    pc,
    output logic [LN_W-1:0]   lane,
    output logic              snap_valid
);

    localparam int PS_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_SCROLL = 2'b01;
    localparam logic [1:0] MODE_SNAP   = 2'b10;
    localparam logic [1:0] MODE_STEP   = 2'b11;

    logic [1:0]      mode_q_reg;
    logic            step_q_reg;
    logic [PS_W-1:0] presc_reg, presc_next;
    logic [LN_W-1:0] lane_reg, lane_next, lane_wrap;
    logic [LW-1:0]   led_reg, led_next;
    logic [PCW-1:0]  pc_reg, pc_next;
    logic [PCW-1:0]  snap_pc_reg;
    logic            snap_valid_reg;

    logic [DW-1:0]   live_ch  [NCH];
    logic [DW-1:0]   snap_reg [NCH];
    logic [DW-1:0]   src_word;

    logic            mode_chg, step_rise, snap_take, presc_tc, sw_ok, use_snap;
    logic [SW_W-1:0] sw_idx;

    assign mode_chg  = (mode != mode_q_reg);
    assign step_rise = step & ~step_q_reg;
    assign snap_take = mode_chg && (mode == MODE_SNAP);
    assign presc_tc  = (presc_reg == PS_W'(SCROLL_DIV - 1));
    assign lane_wrap = (lane_reg == LN_W'(NLANE - 1)) ? '0 : lane_reg + 1'b1;
    // Out-of-range channels (non-power-of-2 NCH) blank the LEDs; index 0 keeps the read in bounds.
    assign sw_ok     = (32'(sw) < NCH);
    assign sw_idx    = sw_ok ? sw : '0;
    // On the capture edge the live value is exactly what is being frozen, so show it directly.
    assign use_snap  = (mode == MODE_SNAP) && !snap_take;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign live_ch[gi] = probe[gi*DW +: DW];

            always_ff @(posedge clk) begin
                if (rst) begin
                    snap_reg[gi] <= '0;
                end else if (snap_take) begin
                    snap_reg[gi] <= live_ch[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        lane_next  = lane_reg;
        presc_next = '0;
        if (mode_chg) begin
            lane_next  = '0;
            presc_next = '0;
        end else begin
            case (mode)
                MODE_SCROLL: begin
                    if (presc_tc) begin
                        presc_next = '0;
                        lane_next  = lane_wrap;
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
                MODE_STEP, MODE_SNAP: begin
                    if (step_rise) begin
                        lane_next = lane_wrap;
                    end
                end
                default: lane_next = '0;
            endcase
        end
    end

    always_comb begin
        src_word = use_snap ? snap_reg[sw_idx] : live_ch[sw_idx];
        led_next = sw_ok ? src_word[lane_next*LW +: LW] : '0;
        pc_next  = use_snap ? snap_pc_reg : pc_in[PCW+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q_reg     <= MODE_STATIC;
            step_q_reg     <= 1'b0;
            presc_reg      <= '0;
            lane_reg       <= '0;
            led_reg        <= '0;
            pc_reg         <= '0;
            snap_pc_reg    <= '0;
            snap_valid_reg <= 1'b0;
        end else begin
            mode_q_reg     <= mode;
            step_q_reg     <= step;
            presc_reg      <= presc_next;
            lane_reg       <= lane_next;
            led_reg        <= led_next;
            pc_reg         <= pc_next;
            snap_valid_reg <= (mode == MODE_SNAP);
            if (snap_take) begin
                snap_pc_reg <= pc_in[PCW+1:2];
            end
        end
    end

    assign led        = led_reg;
    assign pc         = pc_reg;
    assign lane       = lane_reg;
    assign snap_valid = snap_valid_reg;

    generate
        if (PCW + 2 < 32) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^pc_in[31:PCW+2];
        end
    endgenerate

    logic unused_pc_lo;
    assign unused_pc_lo = ^pc_in[1:0];

endmodule
